// File: rtl/peripheral_div.sv
// Memory-mapped restoring divider: CPU loads A and B, starts a division, and
// polls done/busy before reading the quotient and remainder.
module peripheral_div #(
  parameter int DW = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  // state  | meaning
  // S_IDLE | no division pending, result registers hold last value
  // S_RUN  | one quotient bit per cycle, counter tracks iteration
  // S_DONE | result latched, done held high until next start/reset
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [4:0] LAST = 5'(DW - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] q_q, q_d, r_q, r_d;
  logic [DW-1:0] dvd_q, dvd_d, div_q, div_d, rem_q, rem_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          done_q, done_d, busy_q, busy_d;
  logic [31:0]   dout_q, dout_d;

  logic          wr_en, rd_en, start;
  logic [DW:0]   rem_sh, diff;
  logic          ge;
  logic [DW-1:0] rem_nx, dvd_nx;

  assign wr_en = cs & wr;
  assign rd_en = cs & rd;
  assign start = wr_en && (addr == 5'h0C) && d_in[0];
  assign d_out = dout_q;

  // Quotient bits shift into the dividend register as its bits move out;
  // the borrow of the DW+1 bit subtraction decides each bit.
  always_comb begin
    rem_sh = {rem_q, dvd_q[DW-1]};
    diff   = rem_sh - {1'b0, div_q};
    ge     = ~diff[DW];
    rem_nx = ge ? diff[DW-1:0] : rem_sh[DW-1:0];
    dvd_nx = {dvd_q[DW-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    busy_d  = busy_q;
    dout_d  = dout_q;

    if (wr_en && addr == 5'h04) a_d = DW'(d_in);
    if (wr_en && addr == 5'h08) b_d = DW'(d_in);

    if (rd_en) begin
      case (addr)
        5'h10:   dout_d = 32'(q_q);
        5'h14:   dout_d = 32'(r_q);
        5'h18:   dout_d = {31'h0, done_q};
        5'h1C:   dout_d = {31'h0, busy_q};
        default: dout_d = 32'h0;
      endcase
    end

    case (state_q)
      S_RUN: begin
        dvd_d = dvd_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          q_d     = dvd_nx;
          r_d     = rem_nx;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: ;
    endcase

    // A start overrides everything, including a division in flight.
    if (start) begin
      dvd_d   = a_q;
      div_d   = b_q;
      rem_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_peripheral_div.sv
// Bench for peripheral_div: arithmetic reference model checked every cycle,
// directed scenarios with literal results, then randomized bus traffic.
module tb_peripheral_div;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [4:0]  addr = '0;
  logic [15:0] d_in = '0;
  logic [31:0] d_out;

  always #5 clk = ~clk;

  peripheral_div #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs),
    .addr(addr), .rd(rd), .wr(wr), .d_out(d_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a division is just a countdown of DW edges after which
  // the result is A/B and A%B (or all ones and A when B is zero).
  logic [15:0] m_a, m_b, m_sa, m_sb, m_q, m_r;
  logic [31:0] m_dout;
  bit          m_done, m_busy;
  int          m_left;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    logic [31:0] nd;
    if (reset) begin
      m_a = '0; m_b = '0; m_sa = '0; m_sb = '0; m_q = '0; m_r = '0;
      m_dout = '0; m_done = 1'b0; m_busy = 1'b0; m_left = 0;
      chk_en = 1'b1;
    end else begin
      nd = m_dout;
      if (cs && rd) begin
        case (addr)
          5'h10:   nd = {16'h0, m_q};
          5'h14:   nd = {16'h0, m_r};
          5'h18:   nd = {31'h0, m_done};
          5'h1C:   nd = {31'h0, m_busy};
          default: nd = 32'h0;
        endcase
      end
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_sb == 16'h0) begin
            m_q = 16'hFFFF;
            m_r = m_sa;
          end else begin
            m_q = m_sa / m_sb;
            m_r = m_sa % m_sb;
          end
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (cs && wr) begin
        if (addr == 5'h0C && d_in[0]) begin
          m_sa = m_a; m_sb = m_b; m_left = DW;
          m_busy = 1'b1; m_done = 1'b0;
        end else if (addr == 5'h04) begin
          m_a = d_in;
        end else if (addr == 5'h08) begin
          m_b = d_in;
        end
      end
      m_dout = nd;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (d_out !== m_dout) begin
        n_err++;
        $display("FAIL dout_model t=%0t actual=%h required=%h", $time, d_out, m_dout);
      end
    end
  end

  // One call occupies exactly one rising edge with the given bus values.
  task automatic drive(input bit r, input bit c, input bit rr, input bit w,
                       input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    reset = r; cs = c; rd = rr; wr = w; addr = a; d_in = d;
    @(posedge clk);
    #1;
    reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic wreg(input logic [4:0] a, input logic [15:0] d);
    drive(0, 1, 0, 1, a, d);
  endtask

  task automatic go();
    wreg(5'h0C, 16'h0001);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 5'h0, 16'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Literal read check: pins both the DUT and the model to a hand value.
  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
    drive(0, 1, 1, 0, a, 16'h0);
    chk(name, d_out, exp);
    chk({name, "_model"}, m_dout, exp);
  endtask

  logic [4:0] rlist [8] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};

  initial begin
    int op;
    bit r, c, rr, w;
    logic [4:0]  ra;
    logic [15:0] rdat;

    idle(0);
    drive(1, 0, 0, 0, 5'h0, 16'h0);
    drive(1, 1, 0, 1, 5'h04, 16'h1234);
    chk("reset_dout", d_out, 32'h0);
    rd_chk(5'h10, 32'h0, "reset_q");
    rd_chk(5'h18, 32'h0, "reset_done");
    rd_chk(5'h1C, 32'h0, "reset_busy");

    // 100 / 7: the read at edge k returns done as it stood after edge k-1.
    wreg(5'h04, 16'd100);
    wreg(5'h08, 16'd7);
    go();
    for (int k = 2; k <= 18; k++) rd_chk(5'h18, (k == 18) ? 32'h1 : 32'h0, "poll_done");
    rd_chk(5'h10, 32'd14, "q_100_7");
    rd_chk(5'h14, 32'd2, "r_100_7");
    rd_chk(5'h1C, 32'd0, "busy_after");

    wreg(5'h04, 16'hFFFF); wreg(5'h08, 16'h0001); go(); idle(16);
    rd_chk(5'h18, 32'h1, "done_ffff_1");
    rd_chk(5'h10, 32'hFFFF, "q_ffff_1");
    rd_chk(5'h14, 32'h0, "r_ffff_1");

    wreg(5'h04, 16'd5); wreg(5'h08, 16'd9); go(); idle(16);
    rd_chk(5'h10, 32'h0, "q_5_9");
    rd_chk(5'h14, 32'd5, "r_5_9");

    wreg(5'h04, 16'h04D2); wreg(5'h08, 16'h0); go(); idle(16);
    rd_chk(5'h18, 32'h1, "done_div0");
    rd_chk(5'h10, 32'hFFFF, "q_div0");
    rd_chk(5'h14, 32'h04D2, "r_div0");

    // Writing B mid-run must not disturb the running division.
    wreg(5'h04, 16'd100); wreg(5'h08, 16'd7); go();
    idle(3); wreg(5'h08, 16'd10); idle(12);
    rd_chk(5'h18, 32'h1, "done_bwrite");
    rd_chk(5'h10, 32'd14, "q_bwrite");
    rd_chk(5'h14, 32'd2, "r_bwrite");

    // Restart at edge 8 with 50/10; Q read while busy shows the old result.
    wreg(5'h04, 16'd100); wreg(5'h08, 16'd7); go();
    idle(3); wreg(5'h08, 16'd10); wreg(5'h04, 16'd50); idle(1); go();
    rd_chk(5'h10, 32'd14, "q_while_busy");
    rd_chk(5'h1C, 32'h1, "busy_restart");
    idle(13);
    rd_chk(5'h18, 32'h0, "done_edge24");
    rd_chk(5'h18, 32'h1, "done_edge25");
    rd_chk(5'h10, 32'd5, "q_restart");
    rd_chk(5'h14, 32'd0, "r_restart");

    // Reset in the middle of a run.
    wreg(5'h04, 16'd1000); wreg(5'h08, 16'd3); go(); idle(7);
    drive(1, 0, 0, 0, 5'h0, 16'h0);
    chk("midreset_dout", d_out, 32'h0);
    rd_chk(5'h18, 32'h0, "midreset_done");
    rd_chk(5'h1C, 32'h0, "midreset_busy");
    rd_chk(5'h10, 32'h0, "midreset_q");
    rd_chk(5'h14, 32'h0, "midreset_r");
    wreg(5'h04, 16'd1000); wreg(5'h08, 16'd3); go(); idle(16);
    rd_chk(5'h10, 32'd333, "q_after_reset");
    rd_chk(5'h14, 32'd1, "r_after_reset");

    // Bus activity with cs low is invisible.
    drive(0, 0, 0, 1, 5'h04, 16'h7777);
    drive(0, 0, 0, 1, 5'h08, 16'h0001);
    drive(0, 0, 0, 1, 5'h0C, 16'h0001);
    drive(0, 0, 1, 0, 5'h10, 16'h0);
    chk("cs_low_dout", d_out, 32'd1);
    rd_chk(5'h18, 32'h1, "cs_low_done");
    go(); idle(16);
    rd_chk(5'h10, 32'd333, "cs_low_q");
    rd_chk(5'h00, 32'h0, "rd_off0");

    for (int i = 0; i < 4000; i++) begin
      op = $urandom_range(0, 99);
      r = (op < 1);
      c = ($urandom_range(0, 9) != 0);
      rr = 1'b0; w = 1'b0;
      ra = rlist[$urandom_range(0, 7)];
      rdat = 16'($urandom);
      if (op < 15) begin
        w = 1'b1; ra = 5'h04;
      end else if (op < 25) begin
        w = 1'b1; ra = 5'h08;
        if ($urandom_range(0, 3) == 0) rdat = 16'($urandom_range(0, 15));
      end else if (op < 29) begin
        w = 1'b1; ra = 5'h0C;
      end else if (op < 33) begin
        w = 1'b1; ra = 5'($urandom);
      end else if (op < 75) begin
        rr = 1'b1;
        if ($urandom_range(0, 4) == 0) ra = 5'($urandom);
        w = ($urandom_range(0, 4) == 0);
      end
      drive(r, c, rr, w, ra, rdat);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
